accum_arbiter: RTL

- Sequencer and two-port arbiter for the 17-bit accumulator datapath.
- Accepts LOAD/ADD/CLEAR/NOP commands from two requesters over valid/ready, arbitrates round-robin, and drives the operands of an external 16-bit adder.
- Waits a fixed settle time for the adder, then captures the result into the internal accumulator register and reports completion.
- Sits between the switch/button front end (or a test master) and the adder; the accumulator output feeds the hex display and sign LED.

---
 rtl/accum_arbiter_if.sv | 39 +++
 rtl/accum_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/accum_arbiter_if.sv
// Request, completion and adder-operand bus of the accumulator sequencer.
// The requester/test side uses "master"; the sequencer itself uses "slave".
interface accum_arbiter_if;
    logic        req0_valid;
    logic [1:0]  req0_op;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [1:0]  req1_op;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [16:0] add_sum;
    logic [16:0] acc;
    logic        busy;
    logic        done;
    logic        done_id;

    modport master (
        output req0_valid, req0_op, req0_data,
        input  req0_ready,
        output req1_valid, req1_op, req1_data,
        input  req1_ready,
        input  add_a, add_b,
        output add_sum,
        input  acc, busy, done, done_id
    );

    modport slave (
        input  req0_valid, req0_op, req0_data,
        output req0_ready,
        input  req1_valid, req1_op, req1_data,
        output req1_ready,
        output add_a, add_b,
        input  add_sum,
        output acc, busy, done, done_id
    );
endinterface

// File: rtl/accum_arbiter.sv
// Two-requester round-robin sequencer for the 17-bit accumulator: drives an
// external 16-bit adder, waits ADD_WAIT cycles for it to settle, then captures.
module accum_arbiter #(
    parameter int ADD_WAIT = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    accum_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, EXEC} state_t;
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    state_t      state_reg;
    op_t         op_reg;
    logic [15:0] data_reg;
    logic        id_reg;
    logic        last_grant_reg;
    logic [3:0]  cnt_reg;
    logic [16:0] acc_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        done_id_reg;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [1:0]  req_op   [2];
    logic [15:0] req_data [2];

    assign req_valid[0] = bus.req0_valid;
    assign req_valid[1] = bus.req1_valid;
    assign req_op[0]    = bus.req0_op;
    assign req_op[1]    = bus.req1_op;
    assign req_data[0]  = bus.req0_data;
    assign req_data[1]  = bus.req1_data;

    // A requester wins when alone, or on a tie when it was not the last winner.
    // Ready is masked by reset so nothing looks accepted in a reset cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (last_grant_reg != 1'(gi)));
            assign req_ready[gi] = grant[gi] & (state_reg == IDLE) & ~Reset;
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    logic        sel_id;
    op_t         sel_op;
    logic [15:0] sel_data;

    assign sel_id   = grant[1];
    assign sel_op   = op_t'(req_op[sel_id]);
    assign sel_data = req_data[sel_id];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            op_reg         <= OP_NOP;
            data_reg       <= '0;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_id_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|req_ready) begin
                        op_reg         <= sel_op;
                        data_reg       <= sel_data;
                        id_reg         <= sel_id;
                        last_grant_reg <= sel_id;
                        // Only ADD needs the adder to settle; everything else
                        // completes on the following edge.
                        cnt_reg        <= (sel_op == OP_ADD) ? 4'(ADD_WAIT - 1) : 4'd0;
                        state_reg      <= EXEC;
                        busy_reg       <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        case (op_reg)
                            OP_LOAD:  acc_reg <= {1'b0, data_reg};
                            OP_ADD:   acc_reg <= bus.add_sum;
                            OP_CLEAR: acc_reg <= '0;
                            default:  acc_reg <= acc_reg;
                        endcase
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        done_id_reg <= id_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.add_a   = data_reg;
    assign bus.add_b   = acc_reg[15:0];
    assign bus.acc     = acc_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.done_id = done_id_reg;

endmodule
